// File: rtl/dpram_fifo_ctrl.sv
// Requester-side controller that turns an external dual-port RAM (1-cycle registered read)
// into a DEPTH+2 deep FIFO: writes go in through port A, and port B reads feed a 2-entry output buffer.
module dpram_fifo_ctrl #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [AWIDTH:0]   count,
    output logic [AWIDTH-1:0] ram_address_a,
    output logic              ram_wren_a,
    output logic [DWIDTH-1:0] ram_data_a,
    output logic [AWIDTH-1:0] ram_address_b,
    output logic              ram_wren_b,
    input  logic [DWIDTH-1:0] ram_out_b
);

    localparam int CW = AWIDTH + 1;
    localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

    logic [AWIDTH-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [AWIDTH:0]   ramCnt_q, ramCnt_d, count_q, count_d;
    logic              rdInflight_q, rdInflight_d;
    logic [1:0]        bufCnt_q, bufCnt_d;
    logic              head_q, head_d, tail_q, tail_d;
    logic [DWIDTH-1:0] obuf_q [2];

    logic       wrFire, rdFire, push, pop;
    logic [1:0] bufAfterPop;

    always_comb begin
        in_ready     = !reset && (ramCnt_q != DEPTH);
        wrFire       = in_valid && in_ready;
        out_valid    = !reset && (bufCnt_q != 2'd0);
        pop          = out_valid && out_ready;
        push         = rdInflight_q;
        bufAfterPop  = bufCnt_q - {1'b0, pop};
        // A read may only be issued if its word is certain to find a buffer slot when it lands.
        rdFire       = !reset && (ramCnt_q != '0)
                       && ((3'(bufAfterPop) + 3'(rdInflight_q)) < 3'd2);

        wrPtr_d      = wrPtr_q + AWIDTH'(wrFire);
        rdPtr_d      = rdPtr_q + AWIDTH'(rdFire);
        ramCnt_d     = ramCnt_q + CW'(wrFire) - CW'(rdFire);
        rdInflight_d = rdFire;
        bufCnt_d     = bufCnt_q + {1'b0, push} - {1'b0, pop};
        head_d       = head_q ^ pop;
        tail_d       = tail_q ^ push;
        count_d      = ramCnt_d + CW'(rdInflight_d) + CW'(bufCnt_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            ramCnt_q     <= '0;
            rdInflight_q <= 1'b0;
            bufCnt_q     <= 2'd0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            ramCnt_q     <= ramCnt_d;
            rdInflight_q <= rdInflight_d;
            bufCnt_q     <= bufCnt_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
        end
    end

    // The buffer data needs no reset; bufCnt_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            obuf_q[tail_q] <= ram_out_b;
        end
        assert (reset || !(push && bufAfterPop == 2'd2));
    end

    always_comb begin
        out_data      = obuf_q[head_q];
        count         = reset ? '0 : count_q;
        ram_address_a = wrPtr_q;
        ram_wren_a    = wrFire;
        ram_data_a    = in_data;
        ram_address_b = rdPtr_q;
        ram_wren_b    = 1'b0;
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural RAM, a queue-based FIFO model checked every cycle,
// and directed scenarios with literal expectations.
module tb_dpram_fifo_ctrl;

    localparam int AW = 12;
    localparam int DW = 60;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic [AW-1:0] ram_address_a, ram_address_b;
    logic          ram_wren_a, ram_wren_b;
    logic [DW-1:0] ram_data_a, ram_out_b;

    dpram_fifo_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .ram_address_a(ram_address_a), .ram_wren_a(ram_wren_a), .ram_data_a(ram_data_a),
        .ram_address_b(ram_address_b), .ram_wren_b(ram_wren_b), .ram_out_b(ram_out_b)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
        ram_out_b <= mem[ram_address_b];
    end

    int passes = 0;
    int total = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: words sit in the RAM queue, then one in flight, then the 2-entry buffer.
    logic [DW-1:0] ramQ[$];
    logic [DW-1:0] bufQ[$];
    logic          flightV = 1'b0;
    logic [DW-1:0] flightD = '0;
    int            wrPtr = 0, rdPtr = 0;
    bit            mdlWrFire = 1'b0;
    bit            mdlEmpty = 1'b1;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
            checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
            checkOutput("rst_count", 64'(count), 64'd0);
            checkOutput("rst_wren_a", 64'(ram_wren_a), 64'd0);
            ramQ.delete();
            bufQ.delete();
            flightV   = 1'b0;
            wrPtr     = 0;
            rdPtr     = 0;
            mdlWrFire = 1'b0;
        end else begin
            bit expReady, expValid, wr, pp, issue;
            int expCount;
            expReady = (ramQ.size() != DEPTH);
            expValid = (bufQ.size() != 0);
            expCount = ramQ.size() + int'(flightV) + bufQ.size();
            wr       = in_valid && expReady;
            pp       = expValid && out_ready;
            issue    = (ramQ.size() != 0) && (bufQ.size() - int'(pp) + int'(flightV) < 2);
            checkOutput("in_ready", 64'(in_ready), 64'(expReady));
            checkOutput("out_valid", 64'(out_valid), 64'(expValid));
            checkOutput("count", 64'(count), 64'(expCount));
            checkOutput("wren_a", 64'(ram_wren_a), 64'(wr));
            checkOutput("wren_b", 64'(ram_wren_b), 64'd0);
            if (expValid) checkOutput("out_data", 64'(out_data), 64'(bufQ[0]));
            if (wr) begin
                checkOutput("addr_a", 64'(ram_address_a), 64'(wrPtr));
                checkOutput("data_a", 64'(ram_data_a), 64'(in_data));
            end
            if (issue) checkOutput("addr_b", 64'(ram_address_b), 64'(rdPtr));
            if (wr && issue) checkOutput("addr_hazard", 64'(ram_address_a != ram_address_b), 64'd1);
            if (pp) void'(bufQ.pop_front());
            if (flightV) bufQ.push_back(flightD);
            if (bufQ.size() > 2) checkOutput("buf_overflow", 64'(bufQ.size()), 64'd2);
            flightV = issue;
            if (issue) begin
                flightD = ramQ.pop_front();
                rdPtr   = (rdPtr + 1) % DEPTH;
            end
            if (wr) begin
                ramQ.push_back(in_data);
                wrPtr = (wrPtr + 1) % DEPTH;
            end
            mdlWrFire = wr;
        end
        mdlEmpty = (ramQ.size() == 0) && !flightV && (bufQ.size() == 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int n, input logic [DW-1:0] base, input int vPct,
                                 input int rPct, output int cycles);
        int sent = 0;
        cycles = 0;
        while (sent < n && cycles < 60000) begin
            in_valid  = ($urandom_range(99) < vPct);
            in_data   = base + DW'(sent);
            out_ready = ($urandom_range(99) < rPct);
            tick();
            cycles++;
            if (mdlWrFire) sent++;
        end
        in_valid = 1'b0;
        if (sent < n) checkOutput("stream_timeout", 64'(sent), 64'(n));
    endtask

    task automatic drain();
        int cyc = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (!mdlEmpty && cyc < 10000) begin
            tick();
            cyc++;
        end
        if (!mdlEmpty) checkOutput("drain_timeout", 64'(cyc), 64'd0);
    endtask

    initial begin
        #9_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checkOutput("lit_rst_count", 64'(count), 64'd0);
        checkOutput("lit_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single word latency from an empty FIFO.
        in_valid  = 1'b1;
        in_data   = 60'h0AB_CDEF;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("lit_lat_valid_c%0d", k), 64'(out_valid), 64'(k == 3));
            if (k == 0) begin
                checkOutput("lit_wren_c0", 64'(ram_wren_a), 64'd1);
                checkOutput("lit_addr_a_c0", 64'(ram_address_a), 64'd0);
            end
            if (k == 1) begin
                checkOutput("lit_addr_b_c1", 64'(ram_address_b), 64'd0);
                checkOutput("lit_count_c1", 64'(count), 64'd1);
            end
            if (k == 3) checkOutput("lit_data_c3", 64'(out_data), 64'h0AB_CDEF);
            if (k == 4) checkOutput("lit_count_c4", 64'(count), 64'd0);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end

        // Fill to DEPTH+2 with a stalled consumer, keep pushing while full, then drain.
        applyStimulus(4098, '0, 100, 0, cyc);
        in_valid = 1'b1;
        in_data  = 60'd4098;
        for (int k = 0; k < 5; k++) tick();
        @(negedge clk);
        checkOutput("lit_full_count", 64'(count), 64'd4098);
        checkOutput("lit_full_in_ready", 64'(in_ready), 64'd0);
        checkOutput("lit_full_wren", 64'(ram_wren_a), 64'd0);
        @(posedge clk); #1;
        drain();

        // Continuous streaming, both pointers wrap more than twice.
        applyStimulus(10000, 60'h1_0000, 100, 100, cyc);
        checkOutput("lit_stream_cycles", 64'(cyc), 64'd10000);
        drain();

        // Random valid/ready.
        applyStimulus(20000, 60'h10_0000, 50, 50, cyc);
        drain();

        // Mid-stream reset with 37 words held.
        applyStimulus(37, 60'h5000, 100, 0, cyc);
        tick();
        tick();
        @(negedge clk);
        checkOutput("lit_pre_rst_count", 64'(count), 64'd37);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("lit_in_rst_count", 64'(count), 64'd0);
        checkOutput("lit_in_rst_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("lit_post_rst_count", 64'(count), 64'd0);
        checkOutput("lit_post_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("lit_post_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        applyStimulus(50, 60'h100, 100, 100, cyc);
        drain();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
